shift_engine: RTL and testbench

SHIFT_ENGINE -- requirements
Module: shift_engine

---
 rtl/shift_engine.sv | 145 ++++++++++++++
 tb/tb_shift_engine.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_engine.sv
// rtl/shift_engine.sv - multi-cycle LSL/LSR/ASR/ROL/ROR shift engine, falling-edge clocked
// Optional carry_out port enabled by SHIFT_ENGINE_CARRY_EN.
module shift_engine #(
    parameter int WIDTH = 16,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [SHW-1:0]   amount,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
`ifdef SHIFT_ENGINE_CARRY_EN
    output logic             carry_out,
`endif
    output logic             done
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_LSL = 3'd0,
        OP_LSR = 3'd1,
        OP_ASR = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } op_t;

    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0] CNT_ZERO = '0;

    state_t           r_state;
    logic [2:0]       r_mode;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_step;
    logic             w_out_bit;
    logic             w_valid_op;

    assign w_valid_op = (amount != CNT_ZERO) && (mode <= 3'd4);

    // Single-bit step of the captured operation; w_out_bit is the bit pushed out.
    always_comb begin
        w_step    = r_data;
        w_out_bit = 1'b0;
        case (r_mode)
            OP_LSL: begin
                w_step    = {r_data[WIDTH-2:0], serial_in};
                w_out_bit = r_data[WIDTH-1];
            end
            OP_LSR: begin
                w_step    = {serial_in, r_data[WIDTH-1:1]};
                w_out_bit = r_data[0];
            end
            OP_ASR: begin
                w_step    = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
                w_out_bit = r_data[0];
            end
            OP_ROL: begin
                w_step    = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                w_out_bit = r_data[WIDTH-1];
            end
            OP_ROR: begin
                w_step    = {r_data[0], r_data[WIDTH-1:1]};
                w_out_bit = r_data[0];
            end
            default: begin
                w_step    = r_data;
                w_out_bit = 1'b0;
            end
        endcase
    end

`ifdef SHIFT_ENGINE_CARRY_EN
    logic r_carry;

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_carry <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (!load && start && w_valid_op)
                r_carry <= 1'b0;
        end else begin
            r_carry <= w_out_bit;
        end
    end

    assign carry_out = r_carry;
`endif

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_mode  <= 3'd0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (load) begin
                        r_data <= data_in;
                    end else if (start) begin
                        if (w_valid_op) begin
                            r_mode  <= mode;
                            r_cnt   <= amount;
                            r_busy  <= 1'b1;
                            r_state <= ST_SHIFT;
                        end else begin
                            // Zero-length or reserved op: acknowledge without touching data.
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_data <= w_step;
                    r_cnt  <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign data_out = r_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_shift_engine.sv
// tb/tb_shift_engine.sv - scoreboard testbench for shift_engine
module tb_shift_engine;

    localparam int WIDTH = 16;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             clr_n;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             start;
    logic [2:0]       mode;
    logic [SHW-1:0]   amount;
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;
`ifdef SHIFT_ENGINE_CARRY_EN
    logic             carry_out;
`endif

    shift_engine #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .load      (load),
        .data_in   (data_in),
        .start     (start),
        .mode      (mode),
        .amount    (amount),
        .serial_in (serial_in),
        .data_out  (data_out),
        .busy      (busy),
`ifdef SHIFT_ENGINE_CARRY_EN
        .carry_out (carry_out),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             carry;
        int               busy_cycles;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Active edge is negedge; observe 1 time unit after it.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] d, input logic [2:0] m,
                                   input int amt, input logic sin);
        exp_t e;
        e.data = d;
        e.carry = 1'b0;
        e.busy_cycles = 0;
        if (amt == 0 || m > 3'd4) return e;
        e.busy_cycles = amt;
        for (int i = 0; i < amt; i++) begin
            case (m)
                3'd0: begin e.carry = e.data[WIDTH-1]; e.data = e.data << 1; e.data[0] = sin; end
                3'd1: begin e.carry = e.data[0]; e.data = e.data >> 1; e.data[WIDTH-1] = sin; end
                3'd2: begin e.carry = e.data[0]; e.data = $signed(e.data) >>> 1; end
                3'd3: begin e.carry = e.data[WIDTH-1]; e.data = {e.data[WIDTH-2:0], e.data[WIDTH-1]}; end
                default: begin e.carry = e.data[0]; e.data = {e.data[0], e.data[WIDTH-1:1]}; end
            endcase
        end
        return e;
    endfunction

    task automatic do_load(input logic [WIDTH-1:0] v);
        load = 1'b1;
        data_in = v;
        step();
        load = 1'b0;
        cur = v;
        chk("load_data", 32'(data_out), 32'(v));
    endtask

    // Start an op, wait for done, compare against the scoreboard head.
    // b2b leaves the done cycle open for the next start; poke fires load/start mid-shift.
    task automatic run_op(input string tag, input logic [2:0] m, input int amt,
                          input logic sin, input bit b2b, input bit poke);
        exp_t e;
        int   nbusy;
        bit   seen;
        sb.push_back(model(cur, m, amt, sin));
        mode = m;
        amount = SHW'(amt);
        serial_in = sin;
        start = 1'b1;
        step();
        start = 1'b0;
        mode = 3'd7;
        amount = '1;
        nbusy = 0;
        seen = 0;
        for (int i = 0; i < amt + 6; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) nbusy++;
            if (poke && i == 3) begin
                load = 1'b1;
                start = 1'b1;
                data_in = 16'h1234;
            end
            step();
            load = 1'b0;
            start = 1'b0;
        end
        e = sb.pop_front();
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_data"}, 32'(data_out), 32'(e.data));
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(e.busy_cycles));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
`ifdef SHIFT_ENGINE_CARRY_EN
        if (e.busy_cycles > 0) chk({tag, "_carry"}, 32'(carry_out), 32'(e.carry));
`endif
        cur = data_out;
        if (!b2b) begin
            step();
            chk({tag, "_done_single"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        clr_n = 1'b0;
        load = 1'b0;
        data_in = '0;
        start = 1'b0;
        mode = 3'd0;
        amount = '0;
        serial_in = 1'b0;
        cur = '0;
        step();
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        clr_n = 1'b1;
        step();

        do_load(16'h8001);
        run_op("lsl1", 3'd0, 1, 1'b0, 0, 0);
        chk("lsl1_abs", 32'(data_out), 32'h0002);

        do_load(16'h8000);
        run_op("asr4", 3'd2, 4, 1'b0, 0, 0);
        chk("asr4_abs", 32'(data_out), 32'hF800);

        do_load(16'h0001);
        run_op("ror1", 3'd4, 1, 1'b0, 1, 0);
        chk("ror1_abs", 32'(data_out), 32'h8000);
        run_op("rol17", 3'd3, 17, 1'b0, 0, 0);
        chk("rol17_abs", 32'(data_out), 32'h0001);

        do_load(16'hFFFF);
        run_op("lsr20", 3'd1, 20, 1'b0, 0, 1);
        chk("lsr20_abs", 32'(data_out), 32'h0000);

        do_load(16'hA5C3);
        run_op("lsl_fill1", 3'd0, 3, 1'b1, 0, 0);
        run_op("amt0", 3'd0, 0, 1'b0, 0, 0);
        chk("amt0_abs", 32'(data_out), 32'h2E1F);
        run_op("mode6", 3'd6, 3, 1'b0, 0, 0);
        chk("mode6_abs", 32'(data_out), 32'h2E1F);

        do_load(16'h1357);
        mode = 3'd0;
        amount = SHW'(10);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        clr_n = 1'b0;
        #1;
        chk("async_rst_data", 32'(data_out), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        step();
        step();
        chk("rst_hold_done", 32'(done), 32'd0);
        clr_n = 1'b1;
        step();
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        do_load(16'h00FF);
        run_op("post_rst_rol", 3'd3, 4, 1'b0, 0, 0);
        chk("post_rst_rol_abs", 32'(data_out), 32'h0FF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
